rambus_wave_reader: RTL and testbench
=====================================

RAMBUS_WAVE_READER -- requirements
Module: rambus_wave_reader

Interface
REQ-001 The module SHALL have parameter FIFO_DEPTH, default 2: depth of the prefetch word FIFO; it SHALL be a power of two, minimum 2.
REQ-002 The module SHALL have parameter ACK_TIMEOUT, default 15: maximum number of cycles to wait for rambus_wb_ack_i.
REQ-003 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-004 The module SHALL have these ports (name, direction, width, meaning):
- wb_clk_i  in  1  clock
- wb_rst_ni  in  1  async active-low reset
- start  in  1  one-cycle pulse that begins playback
- stop  in  1  one-cycle pulse that aborts playback
- loop_en  in  1  wrap to start_addr after end_addr
- start_addr  in  8  first RAM word address
- end_addr  in  8  last RAM word address, inclusive
- rate_div  in  16  output-strobe divider
- busy  out  1  playback active
- err  out  1  sticky ack-timeout flag
- sample  out  8  current output byte
- sample_stb  out  1  one-cycle strobe when a new sample is presented
- rambus_wb_clk_o  out  1  equals wb_clk_i
- rambus_wb_rst_o  out  1  equals ~wb_rst_ni
- rambus_wb_stb_o  out  1  strobe
- rambus_wb_cyc_o  out  1  cycle
- rambus_wb_we_o  out  1  write enable, tied 0
- rambus_wb_sel_o  out  4  byte select, tied 4'hF
- rambus_wb_dat_o  out  32  write data, tied 0
- rambus_wb_adr_o  out  10  byte address, {word_addr, 2'b00}
- rambus_wb_ack_i  in  1  acknowledge
- rambus_wb_dat_i  in  32  read data

Function
REQ-005 Fetch FSM states SHALL be IDLE, REQ, DONE and ERR.
REQ-006 IDLE SHALL go to REQ on start, loading word_addr from start_addr.
REQ-007 In REQ, stb and cyc SHALL be held high until ack; on ack the FSM SHALL push rambus_wb_dat_i into the FIFO and drop stb/cyc for at least one cycle.
REQ-008 The FSM SHALL issue a REQ only while the FIFO is not full.
REQ-009 After fetching end_addr: with loop_en=1, word_addr SHALL wrap to start_addr and fetching continues; with loop_en=0, the FSM SHALL go to DONE.
REQ-010 Word address increment SHALL be 8-bit modulo, so 8'hFF wraps to 8'h00 when end_addr < start_addr.
REQ-011 If ack is absent for ACK_TIMEOUT consecutive stb cycles, the FSM SHALL drop stb/cyc, set err, and enter ERR.
REQ-012 ERR SHALL be left only via start, which clears err and enters REQ.
REQ-013 The output side SHALL run a 16-bit down-counter reloaded with rate_div; one tick occurs when the counter reaches 0, giving one tick per rate_div+1 cycles.
REQ-014 On each tick with a byte available, sample SHALL be updated and sample_stb SHALL pulse one cycle.
REQ-015 Bytes SHALL be emitted little-endian: byte0 = dat[7:0] first, byte3 last; the FIFO SHALL pop after byte3.
REQ-016 A tick with the FIFO empty SHALL hold sample with no strobe (underrun); the divider SHALL keep counting.
REQ-017 busy SHALL be high from start until DONE, the FIFO is drained, and the last byte is emitted; busy SHALL then drop and the FSM SHALL return to IDLE.
REQ-018 stop SHALL abort any state: stb/cyc drop the same cycle, the FIFO and byte index are flushed, the FSM enters IDLE, and sample holds its value.
REQ-019 If stop and start occur in the same cycle, stop SHALL win.
REQ-020 start while busy SHALL be ignored.
REQ-021 A pending ack in the cycle stop asserts SHALL be discarded.

Reset
REQ-022 While wb_rst_ni=0, all outputs SHALL be 0 except rambus_wb_clk_o (follows the clock), rambus_wb_rst_o=1 and rambus_wb_sel_o=4'hF.
REQ-023 During reset, the FSM SHALL be IDLE, the FIFO empty, the byte index 0, the divider counter 0 and err 0.
REQ-024 Reset deassertion SHALL take effect on the next clock edge, with no request issued before a start.

Structure
REQ-025 A shared package SHALL hold the FSM state enum, the RAM address width constant (8) and the byte-address width constant (10).
REQ-026 The FIFO SHALL be a separate sub-module, sync_word_fifo, with push/pop, full/empty and parameterised depth.

Verification
REQ-027 start=0x10, end=0x11, rate_div=0, RAM 0x10=0x44332211 and 0x11=0x88776655 -> samples 11,22,...,88 on 8 consecutive cycles, then busy falls.
REQ-028 loop_en=1, start=end=0x05, RAM=0xDDCCBBAA -> AA,BB,CC,DD repeats until stop; stb/cyc low the cycle after stop.
REQ-029 A slave that never acks -> stb high for exactly 15 cycles, then err=1 and busy=0; a following start clears err.
REQ-030 rate_div=3 -> sample_stb period 4 cycles; a slave delaying ack 20 cycles with ACK_TIMEOUT=31 causes an underrun with no strobe and correct data afterwards.
REQ-031 start=0xFE, end=0x01 -> addresses fetched 0x3F8, 0x3FC, 0x000, 0x004.
REQ-032 Reset asserted mid-REQ -> stb/cyc/busy/sample_stb are 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/rambus_wave_reader_pkg.sv
// Shared types and constants for the wavetable reader: fetch FSM states,
// address widths and the little-endian byte-lane selector.
package rambus_wave_reader_pkg;

    localparam int RAM_AW  = 8;
    localparam int BYTE_AW = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE,
        ST_ERR
    } fetch_state_e;

    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/rambus_wave_reader_fifo.sv
// Synchronous word FIFO with a flush input; pointers carry an extra wrap bit
// so that full and empty can be told apart.
module sync_word_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (push && !full)
                r_wptr <= r_wptr + 1'b1;
            if (pop && !empty)
                r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !flush)
            r_mem[r_wptr[AW-1:0]] <= din;
    end

    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign dout  = r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/rambus_wave_reader.sv
// Wavetable playback engine: prefetches 32-bit words over Wishbone into a small
// FIFO and emits them byte by byte at a programmable strobe rate.
module rambus_wave_reader
    import rambus_wave_reader_pkg::*;
#(
    parameter int FIFO_DEPTH  = 2,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    input  logic               start,
    input  logic               stop,
    input  logic               loop_en,
    input  logic [RAM_AW-1:0]  start_addr,
    input  logic [RAM_AW-1:0]  end_addr,
    input  logic [15:0]        rate_div,
    output logic               busy,
    output logic               err,
    output logic [7:0]         sample,
    output logic               sample_stb,
    output logic               rambus_wb_clk_o,
    output logic               rambus_wb_rst_o,
    output logic               rambus_wb_stb_o,
    output logic               rambus_wb_cyc_o,
    output logic               rambus_wb_we_o,
    output logic [3:0]         rambus_wb_sel_o,
    output logic [31:0]        rambus_wb_dat_o,
    output logic [BYTE_AW-1:0] rambus_wb_adr_o,
    input  logic               rambus_wb_ack_i,
    input  logic [31:0]        rambus_wb_dat_i
);
    localparam int              TW       = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(ACK_TIMEOUT - 1);

    fetch_state_e      r_state, w_state_nxt;
    logic [RAM_AW-1:0] r_word_addr, w_word_addr_nxt;
    logic [TW-1:0]     r_tmo, w_tmo_nxt;
    logic              r_gap, w_gap_nxt;
    logic              r_err, w_err_nxt;
    logic              w_full, w_empty, w_push, w_pop, w_stb, w_start, w_tick;
    logic [31:0]       w_word;
    logic [15:0]       r_div;
    logic [1:0]        r_byte_idx;
    logic [7:0]        r_sample;
    logic              r_sample_stb;

    // stop kills the bus request combinationally so the slave sees it drop this cycle
    assign w_stb   = (r_state == ST_REQ) && !r_gap && !w_full && !stop;
    assign w_push  = w_stb && rambus_wb_ack_i;
    assign w_start = start && !stop &&
                     ((r_state == ST_IDLE) || (r_state == ST_ERR) ||
                      ((r_state == ST_DONE) && w_empty));

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state     <= ST_IDLE;
            r_word_addr <= '0;
            r_tmo       <= '0;
            r_gap       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_word_addr <= w_word_addr_nxt;
            r_tmo       <= w_tmo_nxt;
            r_gap       <= w_gap_nxt;
            r_err       <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_word_addr_nxt = r_word_addr;
        w_tmo_nxt       = r_tmo;
        w_gap_nxt       = 1'b0;
        w_err_nxt       = r_err;
        if (stop) begin
            w_state_nxt = ST_IDLE;
            w_tmo_nxt   = '0;
        end else if (w_start) begin
            w_state_nxt     = ST_REQ;
            w_word_addr_nxt = start_addr;
            w_tmo_nxt       = '0;
            w_err_nxt       = 1'b0;
        end else begin
            case (r_state)
                ST_REQ: begin
                    if (w_push) begin
                        w_gap_nxt = 1'b1;
                        w_tmo_nxt = '0;
                        if (r_word_addr == end_addr) begin
                            if (loop_en)
                                w_word_addr_nxt = start_addr;
                            else
                                w_state_nxt = ST_DONE;
                        end else begin
                            w_word_addr_nxt = r_word_addr + 1'b1;
                        end
                    end else if (w_stb) begin
                        if (r_tmo == TMO_LAST) begin
                            w_state_nxt = ST_ERR;
                            w_err_nxt   = 1'b1;
                            w_tmo_nxt   = '0;
                        end else begin
                            w_tmo_nxt = r_tmo + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (w_empty)
                        w_state_nxt = ST_IDLE;
                end
                default: begin
                end
            endcase
        end
    end

    sync_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .flush (stop),
        .push  (w_push),
        .pop   (w_pop),
        .din   (rambus_wb_dat_i),
        .dout  (w_word),
        .full  (w_full),
        .empty (w_empty)
    );

    // Divider free-runs; an empty FIFO on a tick is an underrun and just holds sample
    assign w_tick = (r_div == '0);
    assign w_pop  = w_tick && !w_empty && !stop && (r_byte_idx == 2'd3);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_div        <= '0;
            r_byte_idx   <= '0;
            r_sample     <= '0;
            r_sample_stb <= 1'b0;
        end else begin
            r_div        <= w_tick ? rate_div : r_div - 1'b1;
            r_sample_stb <= 1'b0;
            if (stop) begin
                r_byte_idx <= '0;
            end else if (w_tick && !w_empty) begin
                r_sample     <= word_byte(w_word, r_byte_idx);
                r_sample_stb <= 1'b1;
                r_byte_idx   <= r_byte_idx + 1'b1;
            end
        end
    end

    assign busy            = (r_state == ST_REQ) || ((r_state == ST_DONE) && !w_empty);
    assign err             = r_err;
    assign sample          = r_sample;
    assign sample_stb      = r_sample_stb;
    assign rambus_wb_clk_o = wb_clk_i;
    assign rambus_wb_rst_o = ~wb_rst_ni;
    assign rambus_wb_stb_o = w_stb;
    assign rambus_wb_cyc_o = w_stb;
    assign rambus_wb_we_o  = 1'b0;
    assign rambus_wb_sel_o = 4'hF;
    assign rambus_wb_dat_o = '0;
    assign rambus_wb_adr_o = {r_word_addr, 2'b00};

endmodule

// File: tb/tb_rambus_wave_reader.sv
// Scoreboard bench for rambus_wave_reader: two instances (default timeout and a
// 31-cycle timeout) share the control inputs, each with its own RAM slave model.
`timescale 1ns/1ps
module tb_rambus_wave_reader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, stop, loop_en;
    logic [7:0]  start_addr, end_addr;
    logic [15:0] rate_div;

    logic        busy, err, sample_stb, wclk, wrst, stb, cyc, we, ack;
    logic [7:0]  sample;
    logic [3:0]  sel;
    logic [31:0] dato, dati;
    logic [9:0]  adr;

    logic        busy2, err2, sample_stb2, wclk2, wrst2, stb2, cyc2, we2, ack2;
    logic [7:0]  sample2;
    logic [3:0]  sel2;
    logic [31:0] dato2, dati2;
    logic [9:0]  adr2;

    logic [31:0] ram [256];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_n   = 0;

    rambus_wave_reader dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
        .start_addr(start_addr), .end_addr(end_addr), .rate_div(rate_div),
        .busy(busy), .err(err), .sample(sample), .sample_stb(sample_stb),
        .rambus_wb_clk_o(wclk), .rambus_wb_rst_o(wrst), .rambus_wb_stb_o(stb),
        .rambus_wb_cyc_o(cyc), .rambus_wb_we_o(we), .rambus_wb_sel_o(sel),
        .rambus_wb_dat_o(dato), .rambus_wb_adr_o(adr),
        .rambus_wb_ack_i(ack), .rambus_wb_dat_i(dati)
    );

    rambus_wave_reader #(.FIFO_DEPTH(2), .ACK_TIMEOUT(31)) dut2 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
        .start_addr(start_addr), .end_addr(end_addr), .rate_div(rate_div),
        .busy(busy2), .err(err2), .sample(sample2), .sample_stb(sample_stb2),
        .rambus_wb_clk_o(wclk2), .rambus_wb_rst_o(wrst2), .rambus_wb_stb_o(stb2),
        .rambus_wb_cyc_o(cyc2), .rambus_wb_we_o(we2), .rambus_wb_sel_o(sel2),
        .rambus_wb_dat_o(dato2), .rambus_wb_adr_o(adr2),
        .rambus_wb_ack_i(ack2), .rambus_wb_dat_i(dati2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc_n++;

    // Slave for dut: zero-wait ack unless noack; optionally checks fetched addresses
    bit         noack   = 0;
    bit         chk_adr = 0;
    logic [9:0] exp_adr_q[$];
    always @(negedge clk) begin
        if (stb && !noack) begin
            ack  = 1'b1;
            dati = ram[adr[9:2]];
            if (chk_adr) begin
                if (exp_adr_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL adr_extra: got %0h, expected none", adr);
                end else begin
                    check("fetch_adr", 32'(adr), 32'(exp_adr_q.pop_front()));
                end
            end
        end else begin
            ack = 1'b0;
        end
    end

    // Slave for dut2: one selected word is delayed by 20 stb cycles
    bit         slow2 = 0;
    logic [7:0] slow_word = 8'h00;
    int         cnt2 = 0;
    always @(negedge clk) begin
        if (stb2) begin
            if (cnt2 >= ((slow2 && adr2[9:2] == slow_word) ? 20 : 0)) begin
                ack2  = 1'b1;
                dati2 = ram[adr2[9:2]];
            end else begin
                ack2 = 1'b0;
            end
            cnt2++;
        end else begin
            ack2 = 1'b0;
            cnt2 = 0;
        end
    end

    logic [7:0] exp_q[$];
    bit en1 = 0;
    int n_stb1 = 0, last1 = -1, gap_mode = 0;
    always @(negedge clk) begin
        if (en1 && sample_stb) begin
            n_stb1++;
            if (exp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL sample_extra: got %0h, expected none", sample);
            end else begin
                check("sample", 32'(sample), 32'(exp_q.pop_front()));
            end
            if (gap_mode == 1 && last1 >= 0)
                check("stb_consecutive", 32'(cyc_n - last1), 32'd1);
            last1 = cyc_n;
        end
    end

    logic [7:0] exp2_q[$];
    bit en2 = 0;
    int last2 = -1, n_under = 0;
    always @(negedge clk) begin
        if (en2 && sample_stb2) begin
            if (exp2_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL sample2_extra: got %0h, expected none", sample2);
            end else begin
                check("sample2", 32'(sample2), 32'(exp2_q.pop_front()));
            end
            if (last2 >= 0) begin
                check("stb_period_mult4", 32'((cyc_n - last2) % 4), 32'd0);
                if (cyc_n - last2 > 4) n_under++;
            end
            last2 = cyc_n;
        end
    end

    task automatic push_word(input logic [31:0] w, input bit to2);
        for (int b = 0; b < 4; b++) begin
            if (to2) exp2_q.push_back(w[8*b +: 8]);
            else     exp_q.push_back(w[8*b +: 8]);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
    endtask

    task automatic wait_done1(input string name, input int budget);
        int k = 0;
        while ((busy || exp_q.size() != 0) && k < budget) begin
            @(negedge clk); k++;
        end
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n, base;
        logic [7:0] held;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        start_addr = '0; end_addr = '0; rate_div = '0;
        ack = 1'b0; dati = '0; ack2 = 1'b0; dati2 = '0;
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        ram[8'h10] = 32'h44332211; ram[8'h11] = 32'h88776655;
        ram[8'h05] = 32'hDDCCBBAA;
        ram[8'hFE] = 32'hA3A2A1A0; ram[8'hFF] = 32'hB3B2B1B0;
        ram[8'h00] = 32'hC3C2C1C0; ram[8'h01] = 32'hD3D2D1D0;
        ram[8'h20] = 32'h5A6B7C8D;
        ram[8'h30] = 32'h03020100; ram[8'h31] = 32'h13121110; ram[8'h32] = 32'h23222120;

        // reset values
        #12;
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        check("rst_sample", 32'(sample), 0);
        check("rst_sample_stb", 32'(sample_stb), 0);
        check("rst_stb_cyc", 32'({stb, cyc}), 0);
        check("rst_rst_o", 32'(wrst), 1);
        check("rst_sel", 32'(sel), 32'hF);
        check("rst_we_dat_adr", 32'({we, dato[0], adr} | dato), 0);
        check("clk_o_follows", 32'(wclk), 32'(clk));
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("no_req_before_start", 32'(stb), 0);
        check("rst_o_released", 32'(wrst), 0);

        // two-word playback at full rate with address check
        en1 = 1; gap_mode = 1; last1 = -1; chk_adr = 1;
        exp_adr_q = '{10'h040, 10'h044};
        push_word(32'h44332211, 0); push_word(32'h88776655, 0);
        start_addr = 8'h10; end_addr = 8'h11; rate_div = 16'd0;
        pulse_start();
        wait_done1("play2", 200);
        check("play2_adr_left", 32'(exp_adr_q.size()), 0);
        check("play2_sample_hold", 32'(sample), 32'h88);
        gap_mode = 0;

        // address wrap FE..01
        exp_adr_q = '{10'h3F8, 10'h3FC, 10'h000, 10'h004};
        push_word(32'hA3A2A1A0, 0); push_word(32'hB3B2B1B0, 0);
        push_word(32'hC3C2C1C0, 0); push_word(32'hD3D2D1D0, 0);
        start_addr = 8'hFE; end_addr = 8'h01;
        pulse_start();
        wait_done1("wrap", 300);
        check("wrap_adr_left", 32'(exp_adr_q.size()), 0);
        chk_adr = 0;

        // looping single word, then stop
        loop_en = 1'b1; start_addr = 8'h05; end_addr = 8'h05;
        for (int r = 0; r < 6; r++) push_word(32'hDDCCBBAA, 0);
        base = n_stb1;
        pulse_start();
        k = 0;
        while (n_stb1 < base + 12 && k < 200) begin @(negedge clk); k++; end
        check("loop_reached_12", 32'(n_stb1 >= base + 12), 1);
        stop = 1'b1;
        #1;
        check("stop_same_cycle_stb", 32'({stb, cyc}), 0);
        @(negedge clk); stop = 1'b0;
        #1;
        check("stop_next_cycle_stb", 32'({stb, cyc}), 0);
        check("stop_busy", 32'(busy), 0);
        exp_q.delete();
        n = n_stb1; held = sample;
        repeat (20) @(negedge clk);
        check("stop_no_more_strobes", 32'(n_stb1), 32'(n));
        check("stop_sample_hold", 32'(sample), 32'(held));
        check("stop_no_refetch", 32'(stb), 0);
        loop_en = 1'b0;

        // ack timeout, then recovery via start
        noack = 1; start_addr = 8'h20; end_addr = 8'h20;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0; k = 0;
        while (!err && k < 100) begin
            if (stb) n++;
            @(negedge clk); k++;
        end
        check("tmo_stb_cycles", 32'(n), 32'd15);
        check("tmo_err", 32'(err), 1);
        check("tmo_busy", 32'(busy), 0);
        check("tmo_stb_low", 32'(stb), 0);
        noack = 0;
        push_word(32'h5A6B7C8D, 0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("err_cleared", 32'(err), 0);
        check("err_restart_busy", 32'(busy), 1);
        wait_done1("after_err", 200);

        // dut2: divider 3 with a delayed word causing an underrun
        pulse_stop();
        repeat (4) @(negedge clk);
        en1 = 0; en2 = 1; last2 = -1; n_under = 0;
        slow2 = 1; slow_word = 8'h32;
        start_addr = 8'h30; end_addr = 8'h32; rate_div = 16'd3;
        push_word(32'h03020100, 1); push_word(32'h13121110, 1); push_word(32'h23222120, 1);
        pulse_start();
        k = 0;
        while ((busy2 || exp2_q.size() != 0) && k < 400) begin @(negedge clk); k++; end
        check("div3_left", 32'(exp2_q.size()), 0);
        check("div3_busy", 32'(busy2), 0);
        check("div3_err", 32'(err2), 0);
        check("div3_underrun_seen", 32'(n_under != 0), 1);
        en2 = 0; slow2 = 0; rate_div = 16'd0;
        pulse_stop();
        repeat (4) @(negedge clk);

        // reset asserted mid-request
        en1 = 1; noack = 1; start_addr = 8'h40; end_addr = 8'h40;
        pulse_start();
        repeat (3) @(negedge clk);
        check("pre_reset_stb", 32'(stb), 1);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check("async_rst_stb_cyc", 32'({stb, cyc}), 0);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_sample_stb", 32'(sample_stb), 0);
        check("async_rst_sample", 32'(sample), 0);
        @(negedge clk); rst_n = 1'b1; noack = 0;
        repeat (3) @(negedge clk);
        check("post_rst_no_req", 32'(stb), 0);

        // start and stop together: stop wins
        start_addr = 8'h10; end_addr = 8'h11;
        @(negedge clk); start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        check("stop_wins_busy", 32'(busy), 0);
        check("stop_wins_stb", 32'(stb), 0);
        repeat (10) @(negedge clk);
        check("stop_wins_no_samples", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
